// File: rtl/fetch_stage.sv
// fetch_stage: owns the program counter, issues sequential word fetches to
// instruction memory, buffers in-order responses in a small queue and hands
// (insn, pc) pairs to decode. A redirect flushes the queue and drops every
// response still in flight for the old stream.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When defined, a misaligned
// redirect target halts fetch and delivers one faulting NOP entry; otherwise
// the target's low two bits are simply cleared.

module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            insn_valid,
  input  logic            insn_ready,
  output logic [31:0]     insn,
  output logic [XLEN-1:0] pc,
  output logic            fetch_fault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rspPc_q, rspPc_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [31:0]     insnMem [DEPTH];
  logic [XLEN-1:0] pcMem   [DEPTH];

  logic            reqFire, rspLive, rspKeep, rspDrop, deqFire, enq;
  logic            haltedNow, faultEnq;
  logic [31:0]     enqInsn;
  logic [XLEN-1:0] enqPc, redirTarget;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted_q, halted_d, faultPend_q, faultPend_d;
  logic redirHalt;
  logic faultMem [DEPTH];

  // The fault entry waits until every stale response has been dropped, so it
  // lands in an empty queue and reports the raw misaligned target.
  assign redirTarget = redirect_pc;
  assign redirHalt   = (redirect_pc[1:0] != 2'b00);
  assign haltedNow   = halted_q;
  assign faultEnq    = faultPend_q && (discard_q == '0);
  assign fetch_fault = insn_valid && faultMem[rdPtr_q];
`else
  logic unusedRedirLsb;

  assign unusedRedirLsb = ^redirect_pc[1:0];
  assign redirTarget    = {redirect_pc[XLEN-1:2], 2'b00};
  assign haltedNow      = 1'b0;
  assign faultEnq       = 1'b0;
  assign fetch_fault    = 1'b0;
`endif

  // Requests are capped so queued plus in-flight words never exceed DEPTH,
  // which guarantees a free slot for every response that comes back.
  assign imem_req_valid = !rst && !haltedNow &&
                          ((int'(count_q) + int'(outstanding_q)) < DEPTH);
  assign imem_req_addr  = pc_q;
  assign reqFire        = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding belongs to a pre-reset request.
  assign rspLive = imem_rsp_valid && (outstanding_q != '0);
  assign rspDrop = rspLive && (discard_q != '0);
  assign rspKeep = rspLive && (discard_q == '0);

  // Responses come back in order, so the pc of the next kept response is
  // tracked by a counter restarted at every redirect target.
  assign enq     = rspKeep || faultEnq;
  assign enqInsn = faultEnq ? 32'h0000_0013 : imem_rsp_data;
  assign enqPc   = faultEnq ? pc_q : rspPc_q;

  assign insn_valid = (count_q != '0);
  assign deqFire    = insn_valid && insn_ready;
  assign insn       = insn_valid ? insnMem[rdPtr_q] : '0;
  assign pc         = insn_valid ? pcMem[rdPtr_q]   : '0;

  // Next-state logic; a redirect overrides every other update this cycle.
  always_comb begin
    pc_d          = pc_q;
    rspPc_d       = rspPc_q;
    rdPtr_d       = rdPtr_q;
    wrPtr_d       = wrPtr_q;
    count_d       = count_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(reqFire) - CW'(rspLive);
`ifdef FETCH_MISALIGN_TRAP_EN
    halted_d      = halted_q;
    faultPend_d   = faultPend_q;
`endif
    if (redirect_valid) begin
      pc_d      = redirTarget;
      rspPc_d   = redirTarget;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      count_d   = '0;
      discard_d = outstanding_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      halted_d    = redirHalt;
      faultPend_d = redirHalt;
`endif
    end else begin
      if (reqFire) pc_d = pc_q + XLEN'(4);
      if (rspDrop) discard_d = discard_q - CW'(1);
      if (rspKeep) rspPc_d = rspPc_q + XLEN'(4);
      if (enq)     wrPtr_d = wrPtr_q + AW'(1);
      if (deqFire) rdPtr_d = rdPtr_q + AW'(1);
      count_d = count_q + CW'(enq) - CW'(deqFire);
`ifdef FETCH_MISALIGN_TRAP_EN
      if (faultEnq) faultPend_d = 1'b0;
`endif
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      rspPc_q       <= RESET_PC;
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halted_q      <= 1'b0;
      faultPend_q   <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      rspPc_q       <= rspPc_d;
      rdPtr_q       <= rdPtr_d;
      wrPtr_q       <= wrPtr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      halted_q      <= halted_d;
      faultPend_q   <= faultPend_d;
`endif
    end
  end

  // Queue storage; outputs are masked while empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid && enq) begin
      insnMem[wrPtr_q] <= enqInsn;
      pcMem[wrPtr_q]   <= enqPc;
`ifdef FETCH_MISALIGN_TRAP_EN
      faultMem[wrPtr_q] <= faultEnq;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a
// stream-level model: decode must see consecutive word addresses starting at
// the latest redirect target, each carrying the memory word for that address.

module tb_fetch_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            insn_valid;
  logic            insn_ready;
  logic [31:0]     insn;
  logic [XLEN-1:0] pc;
  logic            fetch_fault;

  fetch_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .insn_valid(insn_valid), .insn_ready(insn_ready),
    .insn(insn), .pc(pc), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  int cycleNum, lat, reqReadyPct, insnReadyPct;
  int reqCount, deqCount, faultDeqs, firstValidCycle, lastDue;
  bit doRedirect, lastReqFire, lastRsp, modelHalted, modelFaultPend;
  logic [31:0] redirTarget, expPc, expReqAddr, faultPc, firstValidPc;
  logic [31:0] memAddrQ[$];
  int          memDueQ[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Stream model for one consumed output entry.
  task automatic checkDeq();
`ifdef FETCH_MISALIGN_TRAP_EN
    if (modelFaultPend) begin
      checkOutput("fault_pc", pc, faultPc);
      checkOutput("fault_insn", insn, 32'h0000_0013);
      checkOutput("fault_flag", fetch_fault, 1'b1);
      modelFaultPend = 1'b0;
      faultDeqs++;
      return;
    end
    if (modelHalted) begin
      checkOutput("valid_in_halt", insn_valid, 1'b0);
      return;
    end
`endif
    checkOutput("deq_pc", pc, expPc);
    checkOutput("deq_insn", insn, expPc ^ 32'hA5A5_0000);
    checkOutput("deq_fault", fetch_fault, 1'b0);
    expPc = expPc + 32'd4;
    deqCount++;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; insn_ready = 1'b0;
    doRedirect = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_valid", imem_req_valid, 1'b0);
    checkOutput("rst_insn_valid", insn_valid, 1'b0);
    checkOutput("rst_insn", insn, 32'h0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_fault", fetch_fault, 1'b0);
    memAddrQ.delete();
    memDueQ.delete();
    lastDue = 0;
    rst = 1'b0;
    #1;
    checkOutput("first_req_valid", imem_req_valid, 1'b1);
    checkOutput("first_req_addr", imem_req_addr, 32'h0);
    cycleNum = 1; expPc = '0; expReqAddr = '0;
    modelHalted = 1'b0; modelFaultPend = 1'b0;
    reqCount = 0; deqCount = 0; faultDeqs = 0; firstValidCycle = -1;
  endtask

  // One clock cycle: drive inputs after the falling edge, sample just after,
  // update memory and model, then advance to the next falling edge.
  task automatic applyStimulus();
    bit rspNow, reqFire, deqFire;
    int due;
    rspNow = (memDueQ.size() > 0) && (memDueQ[0] <= cycleNum);
    imem_rsp_valid = rspNow;
    if (rspNow) begin
      imem_rsp_data = memAddrQ[0] ^ 32'hA5A5_0000;
      void'(memAddrQ.pop_front());
      void'(memDueQ.pop_front());
    end else begin
      imem_rsp_data = $urandom;
    end
    imem_req_ready = ($urandom_range(99) < reqReadyPct);
    insn_ready     = ($urandom_range(99) < insnReadyPct);
    redirect_valid = doRedirect;
    redirect_pc    = doRedirect ? redirTarget : $urandom;
    #1;
    reqFire = imem_req_valid && imem_req_ready;
    deqFire = insn_valid && insn_ready;
    lastReqFire = reqFire;
    lastRsp = rspNow;
    if (insn_valid && firstValidCycle < 0) begin
      firstValidCycle = cycleNum;
      firstValidPc = pc;
    end
    if (modelHalted) checkOutput("req_in_halt", imem_req_valid, 1'b0);
    if (deqFire) checkDeq();
    if (reqFire) begin
      checkOutput("req_addr", imem_req_addr, expReqAddr);
      due = cycleNum + lat;
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      memAddrQ.push_back(imem_req_addr);
      memDueQ.push_back(due);
      expReqAddr = expReqAddr + 32'd4;
      reqCount++;
    end
    checkOutput("inflight_cap", memAddrQ.size() <= DEPTH, 1'b1);
    if (doRedirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirTarget[1:0] != 2'b00) begin
        modelHalted = 1'b1; modelFaultPend = 1'b1; faultPc = redirTarget;
        expReqAddr = redirTarget;
      end else begin
        modelHalted = 1'b0; modelFaultPend = 1'b0;
        expPc = redirTarget; expReqAddr = redirTarget;
      end
`else
      expPc = {redirTarget[31:2], 2'b00};
      expReqAddr = expPc;
`endif
    end
    @(posedge clk);
    @(negedge clk);
    cycleNum++;
    if (doRedirect) begin
      checkOutput("redir_flush_valid", insn_valid, 1'b0);
      checkOutput("redir_req_addr", imem_req_addr, expReqAddr);
      doRedirect = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    lat = 1; reqReadyPct = 100; insnReadyPct = 100;

    $display("[TB] phase: streaming with 1-cycle memory");
    resetDut();
    repeat (20) applyStimulus();
    checkOutput("first_valid_cycle", firstValidCycle, 3);
    checkOutput("stream_throughput", deqCount, 18);

    $display("[TB] phase: decode stall then release");
    resetDut();
    insnReadyPct = 0;
    repeat (10) applyStimulus();
    checkOutput("stall_req_count", reqCount, 4);
    checkOutput("stall_req_valid", imem_req_valid, 1'b0);
    checkOutput("stall_insn_valid", insn_valid, 1'b1);
    checkOutput("stall_pc_held", pc, 32'h0);
    insnReadyPct = 100;
    deqCount = 0;
    repeat (5) applyStimulus();
    checkOutput("release_consecutive", deqCount, 5);

    $display("[TB] phase: redirect with stale responses in flight");
    resetDut();
    lat = 3;
    repeat (2) applyStimulus();
    checkOutput("outstanding_pre_redirect", memAddrQ.size(), 2);
    reqReadyPct = 0;
    doRedirect = 1'b1; redirTarget = 32'h0000_0100;
    applyStimulus();
    reqReadyPct = 100;
    repeat (15) applyStimulus();
    checkOutput("flush_first_pc", firstValidPc, 32'h0000_0100);
    checkOutput("flush_progress", deqCount > 0, 1'b1);

    $display("[TB] phase: redirect coinciding with request and response");
    lat = 1;
    repeat (8) applyStimulus();
    doRedirect = 1'b1; redirTarget = 32'h0000_0400;
    applyStimulus();
    checkOutput("redir_coincide", {lastReqFire, lastRsp}, 2'b11);
    repeat (10) applyStimulus();

    $display("[TB] phase: address wrap");
    doRedirect = 1'b1; redirTarget = 32'hFFFF_FFF8;
    applyStimulus();
    repeat (10) applyStimulus();

`ifdef FETCH_MISALIGN_TRAP_EN
    $display("[TB] phase: misaligned redirect trap");
    doRedirect = 1'b1; redirTarget = 32'h0000_0102;
    applyStimulus();
    checkOutput("trap_req_valid", imem_req_valid, 1'b0);
    repeat (10) applyStimulus();
    checkOutput("trap_single_entry", faultDeqs, 1);
    deqCount = 0;
    doRedirect = 1'b1; redirTarget = 32'h0000_0200;
    applyStimulus();
    repeat (10) applyStimulus();
    checkOutput("trap_resume", deqCount > 0, 1'b1);
`else
    $display("[TB] phase: misaligned redirect is aligned");
    doRedirect = 1'b1; redirTarget = 32'h0000_0102;
    applyStimulus();
    repeat (10) applyStimulus();
`endif

    $display("[TB] phase: randomized traffic");
    deqCount = 0;
    reqReadyPct = 70; insnReadyPct = 70;
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(4, 1);
      if ($urandom_range(29) == 0) begin
        doRedirect = 1'b1;
        redirTarget = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
        if ($urandom_range(3) != 0) redirTarget[1:0] = 2'b00;
`endif
      end
      applyStimulus();
    end
    checkOutput("random_progress", deqCount > 0, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
